// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size encodings,
// FSM state type and the natural-alignment check.
package mem_stage_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // An access is naturally aligned when the low address bits below its size are zero.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (off[0] == 1'b0);
            SZ_W:    ok = (off[1:0] == 2'b00);
            SZ_D:    ok = (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering for the LSU: shifts store data and strobes into the bus lanes,
// and extracts/extends load data from a full bus word.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 64
)
(
    input  logic [1:0]                  size_i,
    input  logic                        unsigned_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  logic [XLEN-1:0]             st_data_i,
    output logic [XLEN-1:0]             st_data_o,
    output logic [XLEN/8-1:0]           st_strb_o,
    input  logic [XLEN-1:0]             ld_word_i,
    output logic [XLEN-1:0]             ld_data_o
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [OW+2:0]   sh_s;
    logic [NB-1:0]   strb_base_s;
    logic [XLEN-1:0] ld_shift_s;

    assign sh_s       = {off_i, 3'b000};
    assign st_data_o  = st_data_i << sh_s;
    assign st_strb_o  = strb_base_s << off_i;
    assign ld_shift_s = ld_word_i >> sh_s;

    // Unshifted strobe pattern covering 1 << size bytes.
    always_comb begin
        strb_base_s = '0;
        case (size_i)
            SZ_B:    strb_base_s[0:0] = 1'b1;
            SZ_H:    strb_base_s[1:0] = 2'b11;
            SZ_W:    strb_base_s[3:0] = 4'hF;
            SZ_D:    strb_base_s      = '1;
            default: strb_base_s      = '0;
        endcase
    end

    // Keep the low 8<<size bits and extend; doubleword loads are taken as-is.
    always_comb begin
        ld_data_o = ld_shift_s;
        case (size_i)
            SZ_B:    ld_data_o = {{(XLEN-8){~unsigned_i & ld_shift_s[7]}},   ld_shift_s[7:0]};
            SZ_H:    ld_data_o = {{(XLEN-16){~unsigned_i & ld_shift_s[15]}}, ld_shift_s[15:0]};
            SZ_W:    ld_data_o = {{(XLEN-32){~unsigned_i & ld_shift_s[31]}}, ld_shift_s[31:0]};
            SZ_D:    ld_data_o = ld_shift_s;
            default: ld_data_o = ld_shift_s;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one single-beat bus transaction per memory op, with a
// stall request to the hazard controller and a trap-flush kill path.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid_i,
    input  logic                 mem_wen_i,
    input  logic [1:0]           mem_size_i,
    input  logic                 mem_unsigned_i,
    input  logic [AW-1:0]        mem_addr_i,
    input  logic [XLEN-1:0]      mem_wdata_i,
    input  logic                 wb_stall_i,
    input  logic                 flush_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic                 req_wen_o,
    output logic [AW-1:0]        req_addr_o,
    output logic [XLEN-1:0]      req_wdata_o,
    output logic [XLEN/8-1:0]    req_wstrb_o,
    input  logic                 rsp_valid_i,
    input  logic [XLEN-1:0]      rsp_rdata_i,
    input  logic                 rsp_err_i,
    output logic                 ram_stall_valid_mem_o,
    output logic                 done_o,
    output logic [XLEN-1:0]      load_data_o,
    output logic                 misalign_o,
    output logic                 access_fault_o
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_e      state_q, state_d;
    logic            wen_q, wen_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            kill_q, kill_d;
    logic            misalign_q, misalign_d;
    logic            err_q, err_d;
    logic            done_sent_q, done_sent_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic            aligned_s;
    logic            accept_s;
    logic [XLEN-1:0] st_data_s;
    logic [NB-1:0]   st_strb_s;
    logic [XLEN-1:0] ld_data_s;

    assign aligned_s = is_aligned(mem_size_i, mem_addr_i[2:0]);
    assign accept_s  = (state_q == ST_IDLE) && mem_valid_i && !flush_i;

    // Lane logic always works on the latched op so the request payload stays stable.
    lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .off_i      (addr_q[OW-1:0]),
        .st_data_i  (wdata_q),
        .st_data_o  (st_data_s),
        .st_strb_o  (st_strb_s),
        .ld_word_i  (rsp_rdata_i),
        .ld_data_o  (ld_data_s)
    );

    // State and latched-operation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wen_q       <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            kill_q      <= 1'b0;
            misalign_q  <= 1'b0;
            err_q       <= 1'b0;
            done_sent_q <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            kill_q      <= kill_d;
            misalign_q  <= misalign_d;
            err_q       <= err_d;
            done_sent_q <= done_sent_d;
            load_data_q <= load_data_d;
        end
    end

    // Next-state and capture logic for the four-state transaction FSM.
    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        kill_d      = kill_q;
        misalign_d  = misalign_q;
        err_d       = err_q;
        done_sent_d = done_sent_q;
        load_data_d = load_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && aligned_s) begin
                    wen_d   = mem_wen_i;
                    size_d  = mem_size_i;
                    uns_d   = mem_unsigned_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    state_d = ST_REQ;
                end else if (accept_s) begin
                    misalign_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                kill_d = kill_q | flush_i;
                if (req_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                kill_d = kill_q | flush_i;
                if (rsp_valid_i) begin
                    err_d   = rsp_err_i;
                    state_d = ST_DONE;
                    // A killed or faulting load must not disturb the held result.
                    if (!wen_q && !kill_d && !rsp_err_i) begin
                        load_data_d = ld_data_s;
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                done_sent_d = 1'b1;
                if (!wb_stall_i) begin
                    state_d     = ST_IDLE;
                    kill_d      = 1'b0;
                    misalign_d  = 1'b0;
                    err_d       = 1'b0;
                    done_sent_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_valid_o           = (state_q == ST_REQ);
    assign req_wen_o             = wen_q;
    assign req_addr_o            = {addr_q[AW-1:OW], {OW{1'b0}}};
    assign req_wdata_o           = st_data_s;
    assign req_wstrb_o           = wen_q ? st_strb_s : {NB{1'b0}};
    assign ram_stall_valid_mem_o = (accept_s && aligned_s) || (state_q == ST_REQ) || (state_q == ST_WAIT);
    // done_sent_q limits the pulse to one cycle while MEM_WB holds us in DONE.
    assign done_o                = (state_q == ST_DONE) && !kill_q && !done_sent_q;
    assign misalign_o            = done_o && misalign_q;
    assign access_fault_o        = done_o && err_q;
    assign load_data_o           = load_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of single-op vectors plus hand-written
// sequences for back-pressure, flush, MEM_WB stall and reset corner cases.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_wen_i, mem_unsigned_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic        wb_stall_i, flush_i;
    logic        req_valid_o, req_ready_i, req_wen_o;
    logic [31:0] req_addr_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wstrb_o;
    logic        rsp_valid_i, rsp_err_i;
    logic [63:0] rsp_rdata_i;
    logic        ram_stall_valid_mem_o, done_o, misalign_o, access_fault_o;
    logic [63:0] load_data_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_load = 64'd0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_wen_i(mem_wen_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .wb_stall_i(wb_stall_i), .flush_i(flush_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_wen_o(req_wen_o),
        .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o),
        .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i),
        .ram_stall_valid_mem_o(ram_stall_valid_mem_o), .done_o(done_o),
        .load_data_o(load_data_o), .misalign_o(misalign_o), .access_fault_o(access_fault_o)
    );

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        misal;
        logic [7:0]  strb;
        logic [63:0] req_wdata;
        logic [63:0] load;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mkv(input logic wen, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] rdata, input logic misal,
                                 input logic [7:0] strb, input logic [63:0] req_wdata,
                                 input logic [63:0] load);
        vec_t v;
        v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.misal = misal; v.strb = strb; v.req_wdata = req_wdata; v.load = load;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic wen, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [63:0] wdata);
        mem_valid_i = 1'b1; mem_wen_i = wen; mem_size_i = size;
        mem_unsigned_i = uns; mem_addr_i = addr; mem_wdata_i = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive_op(v.wen, v.size, v.uns, v.addr, v.wdata);
        req_ready_i = 1'b1; rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
        #1 chk($sformatf("v%0d_stall_accept", idx), ram_stall_valid_mem_o, !v.misal);
        @(negedge clk);
        mem_valid_i = 1'b0;
        #1;
        if (v.misal) begin
            chk($sformatf("v%0d_done", idx), done_o, 1'b1);
            chk($sformatf("v%0d_misalign", idx), misalign_o, 1'b1);
            chk($sformatf("v%0d_no_req", idx), req_valid_o, 1'b0);
            chk($sformatf("v%0d_stall_done", idx), ram_stall_valid_mem_o, 1'b0);
        end else begin
            chk($sformatf("v%0d_req_valid", idx), req_valid_o, 1'b1);
            chk($sformatf("v%0d_req_wen", idx), req_wen_o, v.wen);
            chk($sformatf("v%0d_req_addr", idx), req_addr_o, v.addr & 32'hFFFF_FFF8);
            chk($sformatf("v%0d_wstrb", idx), req_wstrb_o, v.strb);
            if (v.wen) chk($sformatf("v%0d_wdata", idx), req_wdata_o, v.req_wdata);
            chk($sformatf("v%0d_stall_req", idx), ram_stall_valid_mem_o, 1'b1);
            @(negedge clk);
            rsp_valid_i = 1'b1; rsp_rdata_i = v.rdata;
            #1 chk($sformatf("v%0d_stall_wait", idx), ram_stall_valid_mem_o, 1'b1);
            chk($sformatf("v%0d_req_dropped", idx), req_valid_o, 1'b0);
            chk($sformatf("v%0d_no_early_done", idx), done_o, 1'b0);
            @(negedge clk);
            rsp_valid_i = 1'b0;
            #1 chk($sformatf("v%0d_done", idx), done_o, 1'b1);
            chk($sformatf("v%0d_stall_done", idx), ram_stall_valid_mem_o, 1'b0);
            chk($sformatf("v%0d_misalign", idx), misalign_o, 1'b0);
            chk($sformatf("v%0d_fault", idx), access_fault_o, 1'b0);
            chk($sformatf("v%0d_load", idx), load_data_o, v.wen ? last_load : v.load);
            if (!v.wen) last_load = v.load;
        end
        @(negedge clk);
        #1 chk($sformatf("v%0d_done_pulse", idx), done_o, 1'b0);
    endtask

    initial begin
        vecs[0]  = mkv(1'b1, 2'd0, 1'b0, 32'h0000_1003, 64'h0000_0000_0000_00AB, 64'd0,
                       1'b0, 8'h08, 64'h0000_0000_AB00_0000, 64'd0);
        vecs[1]  = mkv(1'b0, 2'd1, 1'b0, 32'h0000_2006, 64'd0, 64'h8001_1234_5678_9ABC,
                       1'b0, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_8001);
        vecs[2]  = mkv(1'b0, 2'd1, 1'b1, 32'h0000_2006, 64'd0, 64'h8001_1234_5678_9ABC,
                       1'b0, 8'h00, 64'd0, 64'h0000_0000_0000_8001);
        vecs[3]  = mkv(1'b0, 2'd2, 1'b0, 32'h0000_2004, 64'd0, 64'h8765_4321_0000_0000,
                       1'b0, 8'h00, 64'd0, 64'hFFFF_FFFF_8765_4321);
        vecs[4]  = mkv(1'b0, 2'd0, 1'b1, 32'h0000_3001, 64'd0, 64'h0000_0000_0000_F200,
                       1'b0, 8'h00, 64'd0, 64'h0000_0000_0000_00F2);
        vecs[5]  = mkv(1'b0, 2'd0, 1'b0, 32'h0000_3001, 64'd0, 64'h0000_0000_0000_F200,
                       1'b0, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FFF2);
        vecs[6]  = mkv(1'b0, 2'd3, 1'b1, 32'h0000_4008, 64'd0, 64'hDEAD_BEEF_0123_4567,
                       1'b0, 8'h00, 64'd0, 64'hDEAD_BEEF_0123_4567);
        vecs[7]  = mkv(1'b1, 2'd3, 1'b0, 32'h0000_4010, 64'h1122_3344_5566_7788, 64'd0,
                       1'b0, 8'hFF, 64'h1122_3344_5566_7788, 64'd0);
        vecs[8]  = mkv(1'b1, 2'd1, 1'b0, 32'h0000_5006, 64'h0000_0000_0000_BEEF, 64'd0,
                       1'b0, 8'hC0, 64'hBEEF_0000_0000_0000, 64'd0);
        vecs[9]  = mkv(1'b1, 2'd2, 1'b0, 32'h0000_5004, 64'hFFFF_FFFF_CAFE_F00D, 64'd0,
                       1'b0, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'd0);
        vecs[10] = mkv(1'b0, 2'd2, 1'b0, 32'h0000_1002, 64'd0, 64'd0,
                       1'b1, 8'h00, 64'd0, 64'd0);
        vecs[11] = mkv(1'b1, 2'd3, 1'b0, 32'h0000_4004, 64'h1234, 64'd0,
                       1'b1, 8'h00, 64'd0, 64'd0);
        vecs[12] = mkv(1'b0, 2'd1, 1'b1, 32'h0000_2001, 64'd0, 64'd0,
                       1'b1, 8'h00, 64'd0, 64'd0);

        rst = 1'b1;
        mem_valid_i = 1'b0; mem_wen_i = 1'b0; mem_size_i = 2'd0; mem_unsigned_i = 1'b0;
        mem_addr_i = 32'd0; mem_wdata_i = 64'd0; wb_stall_i = 1'b0; flush_i = 1'b0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_err_i = 1'b0; rsp_rdata_i = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_valid", req_valid_o, 1'b0);
        chk("rst_req_wstrb", req_wstrb_o, 8'h00);
        chk("rst_req_addr", req_addr_o, 32'd0);
        chk("rst_stall", ram_stall_valid_mem_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_load", load_data_o, 64'd0);
        chk("rst_misalign", misalign_o, 1'b0);
        chk("rst_fault", access_fault_o, 1'b0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Bus back-pressure: ready low 5 cycles, stray response while in REQ.
        @(negedge clk);
        drive_op(1'b0, 2'd3, 1'b0, 32'h0000_6000, 64'd0);
        req_ready_i = 1'b0;
        #1 chk("bp_stall_accept", ram_stall_valid_mem_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_valid_i = 1'b0; mem_addr_i = 32'hFFFF_FFFF; mem_size_i = 2'd0;
            rsp_valid_i = (i == 2); rsp_err_i = (i == 2); rsp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
            #1 chk($sformatf("bp_req_valid_%0d", i), req_valid_o, 1'b1);
            chk($sformatf("bp_req_addr_%0d", i), req_addr_o, 32'h0000_6000);
            chk($sformatf("bp_wstrb_%0d", i), req_wstrb_o, 8'h00);
            chk($sformatf("bp_stall_%0d", i), ram_stall_valid_mem_o, 1'b1);
        end
        @(negedge clk);
        rsp_valid_i = 1'b0; rsp_err_i = 1'b0; req_ready_i = 1'b1;
        #1 chk("bp_req_handshake", req_valid_o, 1'b1);
        @(negedge clk);
        req_ready_i = 1'b0;
        #1 chk("bp_wait_noreq", req_valid_o, 1'b0);
        chk("bp_wait_stall", ram_stall_valid_mem_o, 1'b1);
        @(negedge clk);
        rsp_valid_i = 1'b1; rsp_rdata_i = 64'h0123_4567_89AB_CDEF;
        #1 chk("bp_wait_stall2", ram_stall_valid_mem_o, 1'b1);
        @(negedge clk);
        rsp_valid_i = 1'b0;
        #1 chk("bp_done", done_o, 1'b1);
        chk("bp_no_fault", access_fault_o, 1'b0);
        chk("bp_load", load_data_o, 64'h0123_4567_89AB_CDEF);
        chk("bp_stall_release", ram_stall_valid_mem_o, 1'b0);
        last_load = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);

        // Flush during WAIT with a faulting response: silently discarded.
        drive_op(1'b0, 2'd2, 1'b0, 32'h0000_7000, 64'd0);
        req_ready_i = 1'b1;
        #1 chk("fl_stall_accept", ram_stall_valid_mem_o, 1'b1);
        @(negedge clk);
        mem_valid_i = 1'b0;
        #1 chk("fl_req_valid", req_valid_o, 1'b1);
        @(negedge clk);
        req_ready_i = 1'b0; flush_i = 1'b1;
        #1 chk("fl_wait_stall", ram_stall_valid_mem_o, 1'b1);
        @(negedge clk);
        flush_i = 1'b0; rsp_valid_i = 1'b1; rsp_err_i = 1'b1; rsp_rdata_i = 64'h5555_5555_5555_5555;
        #1 chk("fl_wait_stall2", ram_stall_valid_mem_o, 1'b1);
        @(negedge clk);
        rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
        #1 chk("fl_no_done", done_o, 1'b0);
        chk("fl_no_fault", access_fault_o, 1'b0);
        chk("fl_stall_off", ram_stall_valid_mem_o, 1'b0);
        chk("fl_load_held", load_data_o, last_load);
        @(negedge clk);
        #1 chk("fl_idle_no_done", done_o, 1'b0);
        run_vec(vecs[4], 100);

        // MEM_WB stall holds DONE for 3 cycles while a new op waits in EX_MEM.
        @(negedge clk);
        drive_op(1'b0, 2'd2, 1'b0, 32'h0000_8004, 64'd0);
        req_ready_i = 1'b1;
        @(negedge clk);
        mem_valid_i = 1'b0;
        @(negedge clk);
        rsp_valid_i = 1'b1; rsp_rdata_i = 64'h7FFF_0000_1111_2222;
        @(negedge clk);
        rsp_valid_i = 1'b0; wb_stall_i = 1'b1;
        drive_op(1'b1, 2'd3, 1'b0, 32'h0000_9000, 64'hAAAA);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk($sformatf("ws_done_%0d", i), done_o, (i == 0) ? 1'b1 : 1'b0);
            chk($sformatf("ws_load_%0d", i), load_data_o, 64'h0000_0000_7FFF_0000);
            chk($sformatf("ws_no_req_%0d", i), req_valid_o, 1'b0);
            chk($sformatf("ws_stall_%0d", i), ram_stall_valid_mem_o, 1'b0);
        end
        @(negedge clk);
        wb_stall_i = 1'b0; mem_valid_i = 1'b0;
        #1 chk("ws_release_no_done", done_o, 1'b0);
        @(negedge clk);
        #1 chk("ws_idle_no_req", req_valid_o, 1'b0);
        chk("ws_idle_no_done", done_o, 1'b0);
        last_load = 64'h0000_0000_7FFF_0000;

        // Flush while IDLE drops the op outright.
        @(negedge clk);
        drive_op(1'b0, 2'd2, 1'b0, 32'h0000_A000, 64'd0);
        flush_i = 1'b1;
        #1 chk("fi_no_stall", ram_stall_valid_mem_o, 1'b0);
        @(negedge clk);
        mem_valid_i = 1'b0; flush_i = 1'b0;
        #1 chk("fi_no_req", req_valid_o, 1'b0);
        chk("fi_no_done", done_o, 1'b0);

        // Synchronous reset in the middle of a pending request.
        @(negedge clk);
        drive_op(1'b1, 2'd3, 1'b0, 32'h0000_B000, 64'h77);
        req_ready_i = 1'b0;
        @(negedge clk);
        mem_valid_i = 1'b0;
        #1 chk("rm_req_pending", req_valid_o, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rm_req_cleared", req_valid_o, 1'b0);
        chk("rm_stall_cleared", ram_stall_valid_mem_o, 1'b0);
        chk("rm_wstrb_cleared", req_wstrb_o, 8'h00);
        chk("rm_load_cleared", load_data_o, 64'd0);
        @(negedge clk);
        #1 chk("rm_no_done", done_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
